// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//
// Each 32-bit word is shown as eight hex digits. Digit 0 is the rightmost digit
// and comes from data[3:0]. Every digit gets a slot of SCAN_DIV clocks. The
// first GUARD clocks of each slot keep all anodes off, which stops ghosting
// while the segment lines settle.
//
// New words go through two buffers. A load fills the pending buffer. The
// displayed buffer only takes the pending word at a frame boundary, or while
// the scan is disabled. This way a frame never shows part of one word and part
// of another.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; 0 = display dark, scan held at digit 0
//   data[31:0]  word to display
//   load        1-cycle strobe: capture data into the pending buffer
//   dp_mask[7:0] decimal point per digit, 1 = lit (bit i -> digit i)
//   blank_lz    1 = blank leading-zero digits (digit 0 always shown)
//   an[7:0]     anode selects, active-low, an[i] = digit i
//   seg[7:0]    active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   frame_done  1-cycle pulse after the digit 7 slot ends
// -----------------------------------------------------------------------------
module seg7_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [31:0]      DISP_RST  = 32'hAA55_55AA;

    // Hex digit to active-high gfedcba segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      disp_q, disp_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             last_slot;
    logic             swap;
    logic [31:0]      disp_shift;
    logic             lead_zero;

    always_comb begin
        tick      = en && (cnt_q == CNT_LAST);
        last_slot = tick && (idx_q == 3'd7);
        // A disabled scan never shows the buffer, so it is safe to swap then.
        swap      = pend_valid_q && (last_slot || !en);

        // Prescaler and digit index. Both are held at 0 while disabled, so the
        // scan always restarts from digit 0.
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en) begin
            cnt_d = '0;
            idx_d = 3'd0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // The swap reads the old pending word. A load in the same cycle then
        // refills the pending buffer and keeps it valid.
        disp_d       = swap ? pend_q : disp_q;
        pend_d       = load ? data : pend_q;
        pend_valid_d = load ? 1'b1 : (swap ? 1'b0 : pend_valid_q);

        frame_done_d = last_slot;

        // The current digit sits in the low nibble. The digit is a leading
        // zero when it and every higher nibble are all zero.
        disp_shift = disp_q >> {idx_q, 2'b00};
        lead_zero  = blank_lz && (idx_q != 3'd0) && (disp_shift == 32'd0);

        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (en && (cnt_q >= CNT_GUARD)) begin
            an_d       = ~(8'd1 << idx_q);
            seg_d[7]   = ~dp_mask[idx_q];
            seg_d[6:0] = lead_zero ? 7'h7F : ~hex_to_seg(disp_shift[3:0]);
        end
    end

    // Scan state, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            pend_q       <= 32'd0;
            pend_valid_q <= 1'b0;
            disp_q       <= DISP_RST;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
//
// Self-checking bench for seg7_scan with SCAN_DIV=4 and GUARD=1.
//
// The reference model tracks a single position inside the 32-cycle frame. It
// also tracks the pending and displayed words. Every cycle it predicts an, seg
// and frame_done from the display rules. Directed checks with fixed expected
// patterns come first. A randomized run follows.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

    localparam int SD    = 4;
    localparam int GD    = 1;
    localparam int FRAME = 8 * SD;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic [31:0] data     = 32'd0;
    logic        load     = 1'b0;
    logic [7:0]  dp_mask  = 8'd0;
    logic        blank_lz = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .load       (load),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [6:0]  hex_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          pos;
    int          shown_pos;
    logic [31:0] m_pend;
    logic [31:0] m_disp;
    bit          m_pv;

    task automatic model_reset();
        pos    = 0;
        m_pend = 32'd0;
        m_pv   = 1'b0;
        m_disp = 32'hAA55_55AA;
    endtask

    // One clock: predict from the state before the edge and the current inputs,
    // compare after the edge, then advance the model.
    task automatic cyc(input string tag);
        int          d;
        int          c;
        int          next_pos;
        logic [31:0] rest;
        logic [7:0]  e_an;
        logic [7:0]  e_seg;
        logic        e_fd;
        bit          swap;
        e_an  = 8'hFF;
        e_seg = 8'hFF;
        e_fd  = 1'b0;
        if (!en) begin
            shown_pos = -1;
            swap      = m_pv;
            next_pos  = 0;
        end else begin
            shown_pos = pos;
            d = pos / SD;
            c = pos % SD;
            if (c >= GD) begin
                rest       = m_disp >> (4 * d);
                e_an       = ~(8'd1 << d);
                e_seg[7]   = ~dp_mask[d];
                e_seg[6:0] = (blank_lz && d != 0 && rest == 32'd0) ? 7'h7F : ~hex_tab[rest[3:0]];
            end
            e_fd     = (pos == FRAME - 1);
            swap     = e_fd && m_pv;
            next_pos = (pos + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        check_val($sformatf("%s.an", tag), {24'd0, an}, {24'd0, e_an});
        check_val($sformatf("%s.seg", tag), {24'd0, seg}, {24'd0, e_seg});
        check_val($sformatf("%s.fd", tag), {31'd0, frame_done}, {31'd0, e_fd});
        pos = next_pos;
        if (swap) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (load) begin
            m_pend = data;
            m_pv   = 1'b1;
        end
    endtask

    // Advance until the first non-guard cycle of digit dg is on the outputs.
    task automatic wait_digit(input int dg, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            cyc(tag);
            if (shown_pos == dg * SD + GD) begin
                found = 1'b1;
                break;
            end
        end
        check_val($sformatf("%s.reached", tag), {31'd0, found}, 32'd1);
    endtask

    initial begin
        int fd_cnt;

        // Reset state.
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.an", {24'd0, an}, 32'hFF);
        check_val("rst.seg", {24'd0, seg}, 32'hFF);
        check_val("rst.fd", {31'd0, frame_done}, 32'd0);
        model_reset();
        rst_n = 1'b1;

        // Default word after reset: digit 0 = 'A', digit 2 = '5'.
        cyc("boot_guard");
        cyc("boot_d0");
        check_val("boot.d0.an", {24'd0, an}, 32'hFE);
        check_val("boot.d0.seg", {24'd0, seg}, 32'h88);
        wait_digit(2, "boot_d2");
        check_val("boot.d2.an", {24'd0, an}, 32'hFB);
        check_val("boot.d2.seg", {24'd0, seg}, 32'h92);

        // Anode walk over a full frame; exactly one frame_done.
        fd_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            cyc("walk");
            fd_cnt += int'(frame_done);
        end
        check_val("walk.fd_count", fd_cnt, 32'd1);

        // Tear-free load in the middle of a frame.
        wait_digit(3, "tear_d3");
        data = 32'h1234_5678;
        load = 1'b1;
        cyc("tear_load");
        load = 1'b0;
        wait_digit(5, "tear_d5");
        check_val("tear.d5.seg", {24'd0, seg}, 32'h92);
        wait_digit(7, "tear_d7old");
        check_val("tear.d7old.seg", {24'd0, seg}, 32'h88);
        wait_digit(0, "tear_d0new");
        check_val("tear.d0new.an", {24'd0, an}, 32'hFE);
        check_val("tear.d0new.seg", {24'd0, seg}, 32'h80);
        wait_digit(7, "tear_d7new");
        check_val("tear.d7new.an", {24'd0, an}, 32'h7F);
        check_val("tear.d7new.seg", {24'd0, seg}, 32'hF9);

        // Two loads in one frame: only the latest word is displayed.
        wait_digit(1, "multi_l1");
        data = 32'h1111_1111;
        load = 1'b1;
        cyc("multi_load1");
        load = 1'b0;
        wait_digit(4, "multi_l2");
        data     = 32'h0000_0F00;
        load     = 1'b1;
        blank_lz = 1'b1;
        cyc("multi_load2");
        load = 1'b0;
        wait_digit(0, "multi_d0");
        check_val("multi.d0.seg", {24'd0, seg}, 32'hC0);
        wait_digit(1, "multi_d1");
        check_val("multi.d1.seg", {24'd0, seg}, 32'hC0);
        wait_digit(2, "multi_d2");
        check_val("multi.d2.seg", {24'd0, seg}, 32'h8E);
        wait_digit(5, "multi_d5");
        check_val("multi.d5.an", {24'd0, an}, 32'hDF);
        check_val("multi.d5.seg", {24'd0, seg}, 32'hFF);

        // Dropping en swaps in the pending word at once; the scan restarts at digit 0.
        blank_lz = 1'b0;
        wait_digit(3, "en_d3");
        data = 32'h8765_4321;
        load = 1'b1;
        cyc("en_load");
        load = 1'b0;
        en   = 1'b0;
        cyc("en_off");
        check_val("en_off.an", {24'd0, an}, 32'hFF);
        check_val("en_off.seg", {24'd0, seg}, 32'hFF);
        cyc("en_off2");
        en      = 1'b1;
        dp_mask = 8'h01;
        cyc("en_guard");
        cyc("en_d0");
        check_val("en.d0.an", {24'd0, an}, 32'hFE);
        check_val("en.d0.seg", {24'd0, seg}, 32'h79);
        wait_digit(1, "en_d1");
        check_val("en.d1.seg", {24'd0, seg}, 32'hA4);

        // Randomized run against the model.
        for (int k = 0; k < 1500; k++) begin
            en       = ($urandom_range(0, 15) != 0);
            load     = ($urandom_range(0, 9) == 0);
            data     = $urandom >> (4 * $urandom_range(0, 8));
            dp_mask  = 8'($urandom);
            blank_lz = 1'($urandom);
            cyc("rand");
        end

        // Asynchronous reset in the middle of a slot, with a load pending.
        en       = 1'b1;
        load     = 1'b0;
        dp_mask  = 8'h00;
        blank_lz = 1'b0;
        wait_digit(4, "arst_pre");
        data = 32'h0BAD_F00D;
        load = 1'b1;
        cyc("arst_load");
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst.an", {24'd0, an}, 32'hFF);
        check_val("arst.seg", {24'd0, seg}, 32'hFF);
        check_val("arst.fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("arst.hold.an", {24'd0, an}, 32'hFF);
        model_reset();
        rst_n = 1'b1;
        wait_digit(0, "arst_d0");
        check_val("arst.d0.seg", {24'd0, seg}, 32'h88);
        wait_digit(2, "arst_d2");
        check_val("arst.d2.seg", {24'd0, seg}, 32'h92);
        wait_digit(0, "arst_d0b");
        check_val("arst.d0b.seg", {24'd0, seg}, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
